// File: rtl/cam_key_pkg.sv
// Shared types and constants for the camouflage key loader.
// Feature macro CAM_KEY_RELOAD_EN is consumed by cam_key_loader.
package cam_key_pkg;

    localparam int unsigned KEY_W_DEF = 12;
    localparam int unsigned ERR_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cam_key_shreg.sv
// Shadow shift register, bit counter and running parity for one key frame.
// Macro CAM_KEY_RELOAD_EN does not affect this block.
module cam_key_shreg
    import cam_key_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             shift_i,
    input  logic             sdi_i,
    output logic [KEY_W-1:0] shadow_o,
    output logic             last_o,
    output logic             par_o
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 2);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;

    // Bits enter at the MSB and shift down, so the first bit lands in [0]
    // once KEY_W key bits are in; the parity bit only feeds par_q.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        if (start_i) begin
            shadow_d = {sdi_i, {(KEY_W-1){1'b0}}};
            cnt_d    = CNT_W'(1);
            par_d    = sdi_i;
        end else if (shift_i) begin
            if (cnt_q < CNT_W'(KEY_W)) begin
                shadow_d = {sdi_i, shadow_q[KEY_W-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            par_d = par_q ^ sdi_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
        end
    end

    assign shadow_o = shadow_q;
    assign last_o   = (cnt_q == CNT_W'(KEY_W));
    assign par_o    = par_q;

endmodule

// File: rtl/cam_key_loader.sv
// Serial camouflage key loader: frame capture, even-parity check, atomic commit.
// Define CAM_KEY_RELOAD_EN to allow a new frame to replace a committed key.
module cam_key_loader
    import cam_key_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_sdi,
    input  logic                 key_sen,
    input  logic                 key_abort,
    output logic [KEY_W-1:0]     s_key,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 key_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_e state_q, state_d;

    logic [KEY_W-1:0]     s_key_q;
    logic                 key_valid_q;
    logic                 key_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic             sr_start, sr_shift, commit, fail;
    logic [KEY_W-1:0] shadow;
    logic             last_bit, par;

    cam_key_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (sr_start),
        .shift_i  (sr_shift),
        .sdi_i    (key_sdi),
        .shadow_o (shadow),
        .last_o   (last_bit),
        .par_o    (par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (key_sen) state_d = SHIFT;
            end
            SHIFT: begin
                if (key_abort)                state_d = key_valid_q ? LOCKED : IDLE;
                else if (key_sen && last_bit) state_d = CHECK;
            end
            CHECK: begin
                state_d = (!par || key_valid_q) ? LOCKED : IDLE;
            end
            LOCKED: begin
`ifdef CAM_KEY_RELOAD_EN
                if (key_sen) state_d = SHIFT;
`else
                state_d = LOCKED;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_start = 1'b0;
        sr_shift = 1'b0;
        commit   = 1'b0;
        fail     = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                sr_start = key_sen;
            end
            SHIFT: begin
                busy     = 1'b1;
                sr_shift = key_sen && !key_abort;
            end
            CHECK: begin
                busy   = 1'b1;
                commit = !par;
                fail   = par;
            end
            LOCKED: begin
`ifdef CAM_KEY_RELOAD_EN
                sr_start = key_sen;
`endif
            end
            default: ;
        endcase
    end

    // s_key only ever changes on a passing check, so a partial frame is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_key_q     <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            key_err_q <= fail;
            if (commit) begin
                s_key_q     <= shadow;
                key_valid_q <= 1'b1;
            end
            if (fail) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign s_key     = s_key_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
